// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver with a one-entry holding register and framing/overrun pulses.
// The serial line is synchronised first; all timing comes from a fixed cycles-per-bit count.
module uart_rx_frontend #(
  parameter int CYCLES_PER_BIT = 868,
  parameter int CTR_W          = 16
) (
  input  logic       clk,
  input  logic       m_aresetn,
  input  logic       uart_rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  localparam logic [CTR_W-1:0] LP_BIT_LAST  = CTR_W'(CYCLES_PER_BIT - 1);
  localparam logic [CTR_W-1:0] LP_HALF_LAST = CTR_W'(CYCLES_PER_BIT / 2 - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [2:0]       r_state;
  logic [CTR_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_rx_valid;
  logic [7:0]       r_rx_data;
  logic             r_frame_err;
  logic             r_overrun_err;

  logic w_rxd_s;
  logic w_half_hit;
  logic w_bit_hit;
  logic w_stop_sample;
  logic w_deliver;

  assign w_rxd_s       = r_sync2;
  assign w_half_hit    = (r_cnt == LP_HALF_LAST);
  assign w_bit_hit     = (r_cnt == LP_BIT_LAST);
  assign w_stop_sample = (r_state == ST_STOP) && w_bit_hit;
  assign w_deliver     = w_stop_sample && w_rxd_s;

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  // The counter restarts on every state entry and every sample, so bit centres stay
  // anchored to the detected start edge.
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!w_rxd_s) r_state <= ST_START;
        end
        ST_START: begin
          if (w_half_hit) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_state <= w_rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + CTR_W'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_hit) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rxd_s;
            if (r_idx == 3'd7) r_state <= ST_STOP;
            else               r_idx   <= r_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + CTR_W'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_hit) begin
            r_cnt   <= '0;
            r_state <= w_rxd_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            r_cnt <= r_cnt + CTR_W'(1);
          end
        end
        ST_WAIT_HIGH: begin
          r_cnt <= '0;
          if (w_rxd_s) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Handshake: a byte moves to the consumer on any clk edge where rx_valid && rx_ready;
  // rx_data is frozen while rx_valid is high and not yet accepted.
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      r_rx_valid    <= 1'b0;
      r_rx_data     <= 8'h00;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_frame_err   <= w_stop_sample && !w_rxd_s;
      r_overrun_err <= w_deliver && r_rx_valid && !rx_ready;
      if (w_deliver && (!r_rx_valid || rx_ready)) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= r_shift;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_valid    = r_rx_valid;
  assign rx_data     = r_rx_data;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
  assign busy        = (r_state != ST_IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend: frames are modelled at byte level when issued,
// and a monitor checks every accepted byte, error pulse and hold-stability cycle.
module tb_uart_rx_frontend;

  localparam int CPB = 16;

  logic       clk;
  logic       m_aresetn;
  logic       uart_rxd;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;
  logic [2:0] dbg_state;

  int checks;
  int errors;
  int exp_fe;
  int exp_ov;
  int obs_fe;
  int obs_ov;
  bit hold_mode;
  bit m_held;
  bit lazy_done;

  logic [7:0] exp_q[$];

  logic       prev_v;
  logic       prev_r;
  logic       prev_rst;
  logic [7:0] prev_d;

  uart_rx_frontend #(.CYCLES_PER_BIT(CPB), .CTR_W(16)) dut (
    .clk(clk),
    .m_aresetn(m_aresetn),
    .uart_rxd(uart_rxd),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun_err(overrun_err),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: byte-level outcome of one frame given the consumer policy
  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) exp_fe++;
    else if (hold_mode && m_held) exp_ov++;
    else begin
      exp_q.push_back(b);
      if (hold_mode) m_held = 1'b1;
    end
  endtask

  // drivers: all line changes happen 1 time unit after a rising edge
  task automatic drive_bit(input logic lvl, input int n);
    uart_rxd = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_head(input logic [7:0] b);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low);
    send_head(b);
    if (stop_low > 0) drive_bit(1'b0, stop_low);
    drive_bit(1'b1, CPB);
  endtask

  task automatic accept_one();
    for (int i = 0; i < 30 && !rx_valid; i++) begin
      @(posedge clk);
      #1;
    end
    if (rx_valid) begin
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (m_aresetn) begin
      if (frame_err) obs_fe++;
      if (overrun_err) obs_ov++;
      checks++;
      if (frame_err && overrun_err) begin
        errors++;
        $display("FAIL err_exclusive act=both exp=one_at_most t=%0t", $time);
      end
      if (rx_valid && rx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte act=%0h exp=none t=%0t", rx_data, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL rx_byte act=%0h exp=%0h t=%0t", rx_data, e, $time);
          end
        end
      end
      if (prev_rst && prev_v && !prev_r) begin
        checks++;
        if (!rx_valid || rx_data !== prev_d) begin
          errors++;
          $display("FAIL hold_stable act=%0b/%0h exp=1/%0h t=%0t", rx_valid, rx_data, prev_d, $time);
        end
      end
    end
    prev_v   = rx_valid;
    prev_r   = rx_ready;
    prev_d   = rx_data;
    prev_rst = m_aresetn;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog act=running exp=finished t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit saw_busy;
    checks = 0; errors = 0; exp_fe = 0; exp_ov = 0; obs_fe = 0; obs_ov = 0;
    hold_mode = 1'b0; m_held = 1'b0; lazy_done = 1'b0;
    prev_v = 1'b0; prev_r = 1'b0; prev_rst = 1'b0; prev_d = 8'h00;
    m_aresetn = 1'b0;
    uart_rxd  = 1'b1;
    rx_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun_err, 0);
    chk("rst_busy", busy, 0);
    m_aresetn = 1'b1;
    drive_bit(1'b1, 5);

    // frame held with consumer stalled, delivery latency near stop-bit centre
    hold_mode = 1'b1;
    model_frame(8'hA5, 1'b1);
    send_head(8'hA5);
    drive_bit(1'b1, CPB / 2);
    chk("s1_valid_before_centre", rx_valid, 0);
    lat = 0;
    while (!rx_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("s1_latency_window", (lat >= 1 && lat <= 6), 1);
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    chk("s1_valid_held", rx_valid, 1);
    chk("s1_data_held", rx_data, 8'hA5);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    m_held = 1'b0;
    chk("s1_valid_dropped", rx_valid, 0);
    chk("s1_data_kept", rx_data, 8'hA5);

    // short low glitch on idle line
    saw_busy = 1'b0;
    uart_rxd = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) uart_rxd = 1'b1;
      @(posedge clk);
      #1;
      if (busy) saw_busy = 1'b1;
    end
    chk("s2_busy_pulsed", saw_busy, 1);
    chk("s2_busy_idle", busy, 0);
    chk("s2_no_valid", rx_valid, 0);
    chk("s2_fe_count", obs_fe, exp_fe);
    chk("s2_ov_count", obs_ov, exp_ov);

    // broken stop bit, line held low, then a clean frame
    model_frame(8'h3C, 1'b0);
    send_head(8'h3C);
    drive_bit(1'b0, 30);
    chk("s3_frame_err_seen", obs_fe, exp_fe);
    chk("s3_wait_busy", busy, 1);
    chk("s3_no_valid", rx_valid, 0);
    drive_bit(1'b0, 10);
    chk("s3_still_waiting", busy, 1);
    drive_bit(1'b1, CPB);
    chk("s3_back_idle", busy, 0);
    hold_mode = 1'b0;
    rx_ready = 1'b1;
    model_frame(8'h55, 1'b1);
    send_frame(8'h55, 0);
    drive_bit(1'b1, 3);
    rx_ready = 1'b0;
    chk("s3_q_drained", exp_q.size(), 0);

    // overrun: second byte dropped while the first is held
    hold_mode = 1'b1;
    model_frame(8'h11, 1'b1);
    model_frame(8'h22, 1'b1);
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    drive_bit(1'b1, 20);
    chk("s4_valid_held", rx_valid, 1);
    chk("s4_data_first", rx_data, 8'h11);
    chk("s4_overrun_count", obs_ov, exp_ov);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    m_held = 1'b0;
    chk("s4_valid_cleared", rx_valid, 0);
    drive_bit(1'b1, 20);
    chk("s4_no_second", rx_valid, 0);
    chk("s4_q_drained", exp_q.size(), 0);

    // streaming with consumer always ready
    hold_mode = 1'b0;
    rx_ready = 1'b1;
    model_frame(8'h00, 1'b1);
    send_frame(8'h00, 0);
    model_frame(8'hFF, 1'b1);
    send_frame(8'hFF, 0);
    model_frame(8'h81, 1'b1);
    send_frame(8'h81, 0);
    drive_bit(1'b1, 5);
    chk("s5_q_drained", exp_q.size(), 0);
    chk("s5_fe_count", obs_fe, exp_fe);
    chk("s5_ov_count", obs_ov, exp_ov);

    // reset mid-frame discards held byte and partial frame
    rx_ready = 1'b0;
    hold_mode = 1'b1;
    model_frame(8'h33, 1'b1);
    send_frame(8'h33, 0);
    drive_bit(1'b1, 10);
    chk("s6_held_before_reset", rx_data, 8'h33);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(((8'h6E >> i) & 8'h01) != 0, CPB);
    drive_bit(1'b0, CPB / 2);
    m_aresetn = 1'b0;
    uart_rxd = 1'b1;
    exp_q.delete();
    m_held = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("s6_rst_valid", rx_valid, 0);
    chk("s6_rst_data", rx_data, 8'h00);
    chk("s6_rst_fe", frame_err, 0);
    chk("s6_rst_ov", overrun_err, 0);
    chk("s6_rst_busy", busy, 0);
    m_aresetn = 1'b1;
    drive_bit(1'b1, 20);
    chk("s6_no_spurious", rx_valid, 0);
    chk("s6_idle", busy, 0);
    hold_mode = 1'b0;
    rx_ready = 1'b1;
    model_frame(8'h9A, 1'b1);
    send_frame(8'h9A, 0);
    drive_bit(1'b1, 4);
    chk("s6_q_drained", exp_q.size(), 0);

    // random bytes, random idle gaps, consumer always ready
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      model_frame(b, 1'b1);
      send_frame(b, 0);
      drive_bit(1'b1, $urandom_range(0, 20));
    end
    drive_bit(1'b1, 4);
    chk("s7_q_drained", exp_q.size(), 0);

    // random bytes with a consumer that accepts after a random delay
    rx_ready = 1'b0;
    lazy_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 8; n++) begin
          logic [7:0] b;
          b = 8'($urandom_range(0, 255));
          model_frame(b, 1'b1);
          send_frame(b, 0);
          drive_bit(1'b1, $urandom_range(0, 10));
        end
        lazy_done = 1'b1;
      end
      begin
        while (!lazy_done) begin
          @(posedge clk);
          #1;
          if (rx_valid && !rx_ready) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
            rx_ready = 1'b1;
            @(posedge clk);
            #1;
            rx_ready = 1'b0;
          end
        end
      end
    join
    accept_one();
    drive_bit(1'b1, 10);

    chk("end_q_empty", exp_q.size(), 0);
    chk("end_fe_count", obs_fe, exp_fe);
    chk("end_ov_count", obs_ov, exp_ov);
    chk("end_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
